// File: rtl/dvp_camera_emulator_if.sv
// DVP camera bus: pixel clock, frame/line syncs and the data byte.
// The emulator drives the master side; the capture path sits on the slave side.
interface dvp_camera_emulator_if;
    logic       PCLK;
    logic       VSYNC;
    logic       HREF;
    logic [7:0] D;

    modport master (output PCLK, VSYNC, HREF, D);
    modport slave  (input  PCLK, VSYNC, HREF, D);
endinterface

// File: rtl/dvp_camera_emulator.sv
// OV7670-style DVP transmitter producing YCbCr 4:2:2 test frames from CLOCK_24.
// Define DVP_EMU_PCLK_GATE_EN to hold PCLK low whenever HREF is low.
//
// state    | meaning
// S_IDLE   | no frame in progress, waiting for enable on a byte tick
// S_VSYNC  | VSYNC high for VS_LINES lines
// S_VBACK  | back porch, VBP lines
// S_ACTIVE | V_ACTIVE lines carrying pixel data while HREF is high
// S_VFRONT | front porch, VFP lines; frame_done on the last byte
module dvp_camera_emulator #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 288,
    parameter int VS_LINES = 3,
    parameter int VBP      = 17,
    parameter int VFP      = 10,
    parameter int SQ_SIZE  = 64
) (
    input  logic                         CLOCK_24,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic [1:0]                   mode,
    input  logic [9:0]                   sq_x,
    input  logic [9:0]                   sq_y,
    dvp_camera_emulator_if.master        dvp,
    output logic                         frame_done,
    output logic [7:0]                   frame_cnt
);
    localparam int LINE_BYTES = 2 * H_ACTIVE + H_BLANK;
    localparam int TOTAL      = VS_LINES + VBP + V_ACTIVE + VFP;
    localparam int BW         = $clog2(LINE_BYTES);
    localparam int LW         = $clog2(TOTAL);

    localparam logic [BW-1:0] B_LAST     = BW'(LINE_BYTES - 1);
    localparam logic [BW-1:0] B_HREF_END = BW'(2 * H_ACTIVE);
    localparam logic [LW-1:0] L_VS_END   = LW'(VS_LINES - 1);
    localparam logic [LW-1:0] L_VB_END   = LW'(VS_LINES + VBP - 1);
    localparam logic [LW-1:0] L_ACT_END  = LW'(VS_LINES + VBP + V_ACTIVE - 1);
    localparam logic [LW-1:0] L_LAST     = LW'(TOTAL - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VSYNC  = 3'd1;
    localparam logic [2:0] S_VBACK  = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_VFRONT = 3'd4;

    logic [2:0]    state, nxt_state;
    logic [BW-1:0] byte_cnt, nxt_byte;
    logic [LW-1:0] line_cnt, nxt_line;
    logic [1:0]    mode_q, nxt_mode;
    logic [9:0]    sqx_q, sqy_q, nxt_sqx, nxt_sqy;
    logic          pclk_q, vsync_q, href_q;
    logic [7:0]    d_q;
    logic          line_end, frame_end, start;

    // PCLK high means the next edge is the byte tick (PCLK 1->0)
    logic byte_tick;
    assign byte_tick = pclk_q;

    always_comb begin
        nxt_state = state;
        nxt_byte  = byte_cnt;
        nxt_line  = line_cnt;
        line_end  = (byte_cnt == B_LAST);
        frame_end = 1'b0;
        start     = 1'b0;
        if (state == S_IDLE) begin
            if (enable) begin
                nxt_state = S_VSYNC;
                nxt_byte  = '0;
                nxt_line  = '0;
                start     = 1'b1;
            end
        end else begin
            nxt_byte = line_end ? '0 : byte_cnt + 1'b1;
            if (line_end) begin
                nxt_line = line_cnt + 1'b1;
                case (state)
                    S_VSYNC:  if (line_cnt == L_VS_END)  nxt_state = S_VBACK;
                    S_VBACK:  if (line_cnt == L_VB_END)  nxt_state = S_ACTIVE;
                    S_ACTIVE: if (line_cnt == L_ACT_END) nxt_state = S_VFRONT;
                    default: begin
                        if (line_cnt == L_LAST) begin
                            frame_end = 1'b1;
                            nxt_line  = '0;
                            nxt_state = enable ? S_VSYNC : S_IDLE;
                            start     = enable;
                        end
                    end
                endcase
            end
        end
        nxt_mode = start ? mode : mode_q;
        nxt_sqx  = start ? sq_x : sqx_q;
        nxt_sqy  = start ? sq_y : sqy_q;
    end

    // 11-bit bounds so a square hanging off the right/bottom edge clips instead of wrapping
    function automatic logic in_sq(input logic [10:0] x, input logic [10:0] y,
                                   input logic [9:0] sx, input logic [9:0] sy);
        return (x >= {1'b0, sx}) && (x < {1'b0, sx} + 11'(SQ_SIZE)) &&
               (y >= {1'b0, sy}) && (y < {1'b0, sy} + 11'(SQ_SIZE));
    endfunction

    logic [10:0] px, px_even, py;
    logic [7:0]  y_v, cb_v, cr_v, d_n;
    logic        href_n;

    always_comb begin
        px      = 11'(nxt_byte >> 1);
        px_even = {px[10:1], 1'b0};
        py      = 11'(nxt_line) - 11'(VS_LINES + VBP);
        y_v     = 8'd128;
        cb_v    = 8'd128;
        cr_v    = 8'd128;
        case (nxt_mode)
            2'd0: y_v = px[9:2];
            2'd1: y_v = (px[5] ^ py[5]) ? 8'd235 : 8'd16;
            2'd2: begin
                y_v = in_sq(px, py, nxt_sqx, nxt_sqy) ? 8'd145 : 8'd128;
                if (in_sq(px_even, py, nxt_sqx, nxt_sqy)) begin
                    cb_v = 8'd54;
                    cr_v = 8'd34;
                end
            end
            default: y_v = frame_cnt;
        endcase
        href_n = (nxt_state == S_ACTIVE) && (nxt_byte < B_HREF_END);
        d_n    = 8'd0;
        if (href_n) begin
            case (nxt_byte[1:0])
                2'd0:    d_n = cb_v;
                2'd2:    d_n = cr_v;
                default: d_n = y_v;
            endcase
        end
    end

    always_ff @(posedge CLOCK_24 or negedge reset_n) begin
        if (!reset_n) begin
            pclk_q     <= 1'b0;
            state      <= S_IDLE;
            byte_cnt   <= '0;
            line_cnt   <= '0;
            mode_q     <= '0;
            sqx_q      <= '0;
            sqy_q      <= '0;
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            d_q        <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            pclk_q     <= ~pclk_q;
            frame_done <= 1'b0;
            if (byte_tick) begin
                state      <= nxt_state;
                byte_cnt   <= nxt_byte;
                line_cnt   <= nxt_line;
                mode_q     <= nxt_mode;
                sqx_q      <= nxt_sqx;
                sqy_q      <= nxt_sqy;
                vsync_q    <= (nxt_state == S_VSYNC);
                href_q     <= href_n;
                d_q        <= d_n;
                frame_done <= frame_end;
                if (frame_end) frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

`ifdef DVP_EMU_PCLK_GATE_EN
    assign dvp.PCLK = pclk_q & href_q;
`else
    assign dvp.PCLK = pclk_q;
`endif
    assign dvp.VSYNC = vsync_q;
    assign dvp.HREF  = href_q;
    assign dvp.D     = d_q;
endmodule

// File: tb/tb_dvp_camera_emulator.sv
// Self-checking bench for dvp_camera_emulator on a reduced 4x2 frame geometry.
// Honours DVP_EMU_PCLK_GATE_EN when it is defined for the build.
module tb_dvp_camera_emulator;
    localparam int H_ACTIVE   = 4;
    localparam int V_ACTIVE   = 2;
    localparam int H_BLANK    = 4;
    localparam int VS_LINES   = 1;
    localparam int VBP        = 1;
    localparam int VFP        = 1;
    localparam int SQ_SIZE    = 64;
    localparam int LINE_BYTES = 12;
    localparam int FRAME_CYC  = 120;
    localparam int MODE3_VEC  = 6;
    localparam int NVEC       = 7;
`ifdef DVP_EMU_PCLK_GATE_EN
    localparam int PCLK_PER_LINE = 8;
    localparam int PCLK_IDLE_30  = 0;
`else
    localparam int PCLK_PER_LINE = 12;
    localparam int PCLK_IDLE_30  = 15;
`endif

    logic       CLOCK_24 = 1'b0;
    logic       reset_n  = 1'b0;
    logic       enable   = 1'b0;
    logic [1:0] mode     = 2'd0;
    logic [9:0] sq_x     = 10'd0;
    logic [9:0] sq_y     = 10'd0;
    logic       frame_done;
    logic [7:0] frame_cnt;

    dvp_camera_emulator_if dvp ();

    dvp_camera_emulator #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
        .VS_LINES(VS_LINES), .VBP(VBP), .VFP(VFP), .SQ_SIZE(SQ_SIZE)
    ) dut (
        .CLOCK_24   (CLOCK_24),
        .reset_n    (reset_n),
        .enable     (enable),
        .mode       (mode),
        .sq_x       (sq_x),
        .sq_y       (sq_y),
        .dvp        (dvp.master),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 CLOCK_24 = ~CLOCK_24;

    // Expected PCLK phase: toggles every CLOCK_24 edge once reset is released
    logic ph;
    always @(posedge CLOCK_24 or negedge reset_n)
        if (!reset_n) ph <= 1'b0;
        else          ph <= ~ph;

    typedef struct {
        int mode;
        int sx;
        int sy;
        int exp [16];
    } vec_t;

    vec_t       vecs [NVEC];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         fd_count = 0;
    int         pclk_rises = 0;
    int         fd_cyc [$];
    logic       pclk_prev = 1'b0;
    logic       fd_prev = 1'b0;
    logic [7:0] exp_q [$];
    bit         sb_on = 1'b1;
    logic [7:0] fc_model = 8'd0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One CLOCK_24 cycle: observe at the falling edge, away from the active edge
    task automatic tick_cycle();
        @(negedge CLOCK_24);
        cyc++;
        if (frame_done) begin
            check("frame_done_width", int'(fd_prev), 0);
            fd_count++;
            fd_cyc.push_back(cyc);
        end
        fd_prev = frame_done;
        if (dvp.PCLK && !pclk_prev) pclk_rises++;
        pclk_prev = dvp.PCLK;
        if (ph && reset_n) begin
`ifdef DVP_EMU_PCLK_GATE_EN
            check("pclk_level", int'(dvp.PCLK), int'(dvp.HREF));
`else
            check("pclk_level", int'(dvp.PCLK), 1);
`endif
            if (!dvp.HREF) begin
                check("d_blank_zero", int'(dvp.D), 0);
            end else if (sb_on) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: byte %0d with no expected value (cycle %0d)", dvp.D, cyc);
                end else begin
                    check("d_byte", int'(dvp.D), int'(exp_q.pop_front()));
                end
            end
        end
    endtask

    task automatic sample_byte();
        do tick_cycle(); while (!ph);
    endtask

    task automatic push_frame(input int vi, input logic [7:0] fc);
        logic [7:0] b;
        for (int i = 0; i < 16; i++) begin
            b = 8'(vecs[vi].exp[i]);
            if (vecs[vi].mode == 3 && (i % 2) == 1) b = fc;
            exp_q.push_back(b);
        end
    endtask

    // One frame from IDLE; pattern inputs are disturbed after frame start to prove they were latched
    task automatic run_frame(input int vi);
        int n, fd0, vs_hi, r0;
        mode = 2'(vecs[vi].mode);
        sq_x = 10'(vecs[vi].sx);
        sq_y = 10'(vecs[vi].sy);
        push_frame(vi, fc_model);
        fd0    = fd_count;
        enable = 1'b1;
        n = 0;
        while (!dvp.VSYNC && n < 100) begin tick_cycle(); n++; end
        check("vsync_start", int'(dvp.VSYNC), 1);
        enable = 1'b0;
        mode   = mode ^ 2'd1;
        sq_x   = sq_x + 10'd1;
        sq_y   = sq_y + 10'd1;
        n = 0;
        while (fd_count == fd0 && n < 400) begin tick_cycle(); n++; end
        fc_model++;
        vs_hi = 0;
        r0    = pclk_rises;
        repeat (30) begin tick_cycle(); vs_hi += int'(dvp.VSYNC); end
        check("frame_once", fd_count - fd0, 1);
        check("idle_vsync", vs_hi, 0);
        check("idle_pclk", pclk_rises - r0, PCLK_IDLE_30);
        check("frame_cnt", int'(frame_cnt), int'(fc_model));
        check("sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        int n, hi, lo, r0, fd0;
        vecs[0] = '{0, 0, 0,    '{128,0,128,0,128,0,128,0, 128,0,128,0,128,0,128,0}};
        vecs[1] = '{1, 0, 0,    '{128,16,128,16,128,16,128,16, 128,16,128,16,128,16,128,16}};
        vecs[2] = '{2, 2, 1,    '{128,128,128,128,128,128,128,128, 128,128,128,128,54,145,34,145}};
        vecs[3] = '{2, 0, 0,    '{54,145,34,145,54,145,34,145, 54,145,34,145,54,145,34,145}};
        vecs[4] = '{2, 1, 0,    '{128,128,128,145,54,145,34,145, 128,128,128,145,54,145,34,145}};
        vecs[5] = '{2, 3, 0,    '{128,128,128,128,128,128,128,145, 128,128,128,128,128,128,128,145}};
        vecs[6] = '{3, 0, 0,    '{128,0,128,0,128,0,128,0, 128,0,128,0,128,0,128,0}};

        // reset state
        repeat (3) tick_cycle();
        check("rst_pclk", int'(dvp.PCLK), 0);
        check("rst_vsync", int'(dvp.VSYNC), 0);
        check("rst_href", int'(dvp.HREF), 0);
        check("rst_d", int'(dvp.D), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_frame_cnt", int'(frame_cnt), 0);
        reset_n = 1'b1;
        r0 = pclk_rises;
        repeat (30) tick_cycle();
        check("idle_pclk_free", pclk_rises - r0, PCLK_IDLE_30);
        check("idle_no_vsync", int'(dvp.VSYNC), 0);

        // back-to-back mode 0 frames: sync timing and frame period
        mode = 2'd0; sq_x = 10'd0; sq_y = 10'd0;
        for (int f = 0; f < 3; f++) push_frame(0, 8'd0);
        fd0 = fd_count;
        fd_cyc.delete();
        enable = 1'b1;
        n = 0;
        do begin sample_byte(); n++; end while (!dvp.VSYNC && n < 50);
        hi = 0;
        while (dvp.VSYNC && hi < 100) begin hi++; sample_byte(); end
        check("vsync_len", hi, LINE_BYTES);
        lo = 0;
        while (!dvp.HREF && lo < 100) begin lo++; sample_byte(); end
        check("href_delay", lo, LINE_BYTES);
        r0 = pclk_rises;
        repeat (LINE_BYTES) sample_byte();
        check("pclk_per_line", pclk_rises - r0, PCLK_PER_LINE);
        n = 0;
        while (fd_count - fd0 < 2 && n < 400) begin tick_cycle(); n++; end
        enable = 1'b0;
        n = 0;
        while (fd_count - fd0 < 3 && n < 400) begin tick_cycle(); n++; end
        check("b2b_frames", fd_count - fd0, 3);
        if (fd_cyc.size() >= 3) begin
            check("fd_period_1", fd_cyc[1] - fd_cyc[0], FRAME_CYC);
            check("fd_period_2", fd_cyc[2] - fd_cyc[1], FRAME_CYC);
        end
        fc_model = 8'd3;
        repeat (40) tick_cycle();
        check("b2b_stop", fd_count - fd0, 3);
        check("b2b_frame_cnt", int'(frame_cnt), int'(fc_model));
        check("b2b_drained", exp_q.size(), 0);

        // table-driven single frames
        for (int vi = 0; vi < NVEC; vi++) run_frame(vi);

        // mode 3 across the 255->0 wrap of frame_cnt
        mode = 2'd3;
        fd0  = fd_count;
        for (int f = 0; f < 257; f++) push_frame(MODE3_VEC, 8'(int'(fc_model) + f));
        enable = 1'b1;
        n = 0;
        while (fd_count - fd0 < 256 && n < 257 * FRAME_CYC + 400) begin tick_cycle(); n++; end
        enable = 1'b0;
        n = 0;
        while (fd_count - fd0 < 257 && n < 400) begin tick_cycle(); n++; end
        check("mode3_frames", fd_count - fd0, 257);
        fc_model = 8'(int'(fc_model) + 257);
        repeat (20) tick_cycle();
        check("mode3_frame_cnt", int'(frame_cnt), int'(fc_model));
        check("mode3_drained", exp_q.size(), 0);

        // reset in the middle of an active line
        sb_on  = 1'b0;
        mode   = 2'd0;
        enable = 1'b1;
        n = 0;
        while (!dvp.HREF && n < 300) begin tick_cycle(); n++; end
        check("reach_active", int'(dvp.HREF), 1);
        fd0 = fd_count;
        @(posedge CLOCK_24);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_pclk", int'(dvp.PCLK), 0);
        check("mid_rst_vsync", int'(dvp.VSYNC), 0);
        check("mid_rst_href", int'(dvp.HREF), 0);
        check("mid_rst_d", int'(dvp.D), 0);
        check("mid_rst_frame_done", int'(frame_done), 0);
        check("mid_rst_frame_cnt", int'(frame_cnt), 0);
        enable = 1'b0;
        repeat (20) tick_cycle();
        reset_n = 1'b1;
        repeat (200) tick_cycle();
        check("mid_rst_no_done", fd_count - fd0, 0);
        check("mid_rst_cnt_after", int'(frame_cnt), 0);
        check("mid_rst_idle", int'(dvp.VSYNC), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
